// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, mid-bit sampling.
//   sys_clk          system clock, all logic on rising edge
//   sys_rst          synchronous active-high reset
//   uart_rxd_i       asynchronous serial line, idles high
//   uart_rxdata_o    last correctly framed byte, held until the next good frame
//   uart_rx_done_o   one-cycle strobe, uart_rxdata_o valid in the same cycle
//   uart_rx_busy_o   high while a frame is in progress (START/DATA/STOP)
//   uart_frame_err_o one-cycle strobe when the stop bit is sampled low
module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BPS      = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rxd_i,
  output logic [7:0] uart_rxdata_o,
  output logic       uart_rx_done_o,
  output logic       uart_rx_busy_o,
  output logic       uart_frame_err_o
);

  localparam int COUNT = CLK_FREQ / BPS;
  localparam int HALF  = COUNT / 2;
  localparam logic [15:0] CNT_BIT  = 16'(COUNT - 1);
  localparam logic [15:0] CNT_HALF = 16'(HALF - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_nxt;
  logic        s1, s2, s3;
  logic        fall;
  logic [15:0] cnt_bps;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;
  logic        half_hit, bit_hit;

  // Synchronizer resets low so a line already idling high after reset
  // looks like a rising edge, never a false start.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= uart_rxd_i;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign fall     = ~s2 & s3;
  assign half_hit = (cnt_bps == CNT_HALF);
  assign bit_hit  = (cnt_bps == CNT_BIT);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (fall) state_nxt = START;
      // A start bit that is high again at mid-bit was a glitch.
      START: if (half_hit) state_nxt = s2 ? IDLE : DATA;
      DATA:  if (bit_hit && bit_idx == 3'd7) state_nxt = STOP;
      // Leave at mid-stop so a following start edge is not missed.
      STOP:  if (bit_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_bps          <= '0;
      bit_idx          <= '0;
      shift_reg        <= '0;
      uart_rxdata_o    <= '0;
      uart_rx_done_o   <= 1'b0;
      uart_frame_err_o <= 1'b0;
    end else begin
      uart_rx_done_o   <= 1'b0;
      uart_frame_err_o <= 1'b0;
      case (state)
        IDLE: begin
          cnt_bps <= '0;
          bit_idx <= '0;
        end
        START: begin
          cnt_bps <= half_hit ? 16'd0 : cnt_bps + 16'd1;
          bit_idx <= '0;
        end
        DATA: begin
          if (bit_hit) begin
            shift_reg[bit_idx] <= s2;
            bit_idx            <= bit_idx + 3'd1;
            cnt_bps            <= '0;
          end else begin
            cnt_bps <= cnt_bps + 16'd1;
          end
        end
        STOP: begin
          if (bit_hit) begin
            cnt_bps <= '0;
            if (s2) begin
              uart_rxdata_o  <= shift_reg;
              uart_rx_done_o <= 1'b1;
            end else begin
              uart_frame_err_o <= 1'b1;
            end
          end else begin
            cnt_bps <= cnt_bps + 16'd1;
          end
        end
        default: cnt_bps <= '0;
      endcase
    end
  end

  assign uart_rx_busy_o = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at COUNT=10, HALF=5 (clock period 10 units,
// so one bit is 100 units; fractional bit rates are exact integers).
module tb_uart_rx;
  localparam int CLK_FREQ = 1_000_000;
  localparam int BPS      = 100_000;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       uart_rxd_i = 1'b1;
  logic [7:0] uart_rxdata_o;
  logic       uart_rx_done_o, uart_rx_busy_o, uart_frame_err_o;

  int n_vec = 0, n_bad = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, long_cnt = 0;
  int busy_cnt = 0, busy_rise = 0;
  logic prev_done = 1'b0, prev_err = 1'b0, prev_busy = 1'b0;
  logic [7:0] rx_q[$];
  int done_cyc_q[$];
  int d0, e0, t0, lat;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BPS(BPS)) dut (
    .sys_clk          (sys_clk),
    .sys_rst          (sys_rst),
    .uart_rxd_i       (uart_rxd_i),
    .uart_rxdata_o    (uart_rxdata_o),
    .uart_rx_done_o   (uart_rx_done_o),
    .uart_rx_busy_o   (uart_rx_busy_o),
    .uart_frame_err_o (uart_frame_err_o)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  always @(negedge sys_clk) begin
    if (uart_rx_done_o) begin
      done_cnt++;
      rx_q.push_back(uart_rxdata_o);
      done_cyc_q.push_back(cyc);
    end
    if (uart_frame_err_o) err_cnt++;
    if (uart_rx_done_o && uart_frame_err_o) both_cnt++;
    if ((uart_rx_done_o && prev_done) || (uart_frame_err_o && prev_err)) long_cnt++;
    if (uart_rx_busy_o) busy_cnt++;
    if (uart_rx_busy_o && !prev_busy) busy_rise = cyc;
    prev_done = uart_rx_done_o;
    prev_err  = uart_frame_err_o;
    prev_busy = uart_rx_busy_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qdata(input int i);
    return (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] qcyc(input int i);
    return (i < done_cyc_q.size()) ? 32'(done_cyc_q[i]) : 32'hDEAD;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  // Line changes land 3 units after a rising edge, never on it.
  task automatic align();
    @(posedge sys_clk);
    #3;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stp, input int bt);
    uart_rxd_i = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      uart_rxd_i = b[i];
      #(bt);
    end
    uart_rxd_i = stp;
    #(bt);
  endtask

  task automatic mark();
    d0 = done_cnt;
    e0 = err_cnt;
    busy_cnt = 0;
    rx_q.delete();
    done_cyc_q.delete();
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_data", 32'(uart_rxdata_o), 32'h00);
    check("rst_done", 32'(uart_rx_done_o), 32'h0);
    check("rst_busy", 32'(uart_rx_busy_o), 32'h0);
    check("rst_err",  32'(uart_frame_err_o), 32'h0);
    sys_rst = 1'b0;
    cycles(20);

    // single byte at nominal rate
    mark();
    align();
    t0 = cyc;
    send_frame(8'hA5, 1'b1, 100);
    cycles(20);
    check("a5_done_n", 32'(done_cnt - d0), 32'd1);
    check("a5_data",   32'(uart_rxdata_o), 32'hA5);
    check("a5_err_n",  32'(err_cnt - e0), 32'd0);
    check("a5_busy_rise", 32'(busy_rise - t0), 32'd3);
    check("a5_busy_len",  32'(busy_cnt), 32'd95);
    lat = int'(qcyc(0)) - t0;
    check("a5_latency_98_100", 32'(lat >= 98 && lat <= 100), 32'd1);

    // back-to-back frames, no idle gap
    mark();
    align();
    send_frame(8'h00, 1'b1, 100);
    send_frame(8'hFF, 1'b1, 100);
    send_frame(8'h3C, 1'b1, 100);
    cycles(20);
    check("b2b_done_n", 32'(done_cnt - d0), 32'd3);
    check("b2b_d0", qdata(0), 32'h00);
    check("b2b_d1", qdata(1), 32'hFF);
    check("b2b_d2", qdata(2), 32'h3C);
    check("b2b_gap01", qcyc(1) - qcyc(0), 32'd100);
    check("b2b_gap12", qcyc(2) - qcyc(1), 32'd100);
    check("b2b_err_n", 32'(err_cnt - e0), 32'd0);

    // 3-clock low glitch: false start
    mark();
    align();
    uart_rxd_i = 1'b0;
    #30;
    uart_rxd_i = 1'b1;
    cycles(30);
    check("gl_busy_len", 32'(busy_cnt), 32'd5);
    check("gl_done_n",   32'(done_cnt - d0), 32'd0);
    check("gl_err_n",    32'(err_cnt - e0), 32'd0);
    check("gl_data",     32'(uart_rxdata_o), 32'h3C);
    check("gl_busy",     32'(uart_rx_busy_o), 32'd0);

    // low stop bit, then line held low (break)
    mark();
    align();
    send_frame(8'h55, 1'b0, 100);
    cycles(500);
    check("fe_err_n",  32'(err_cnt - e0), 32'd1);
    check("fe_done_n", 32'(done_cnt - d0), 32'd0);
    check("fe_data",   32'(uart_rxdata_o), 32'h3C);
    uart_rxd_i = 1'b1;
    cycles(20);
    check("fe_err_after_release", 32'(err_cnt - e0), 32'd1);
    check("fe_busy", 32'(uart_rx_busy_o), 32'd0);

    // reset during bit 4, then a clean frame
    mark();
    align();
    uart_rxd_i = 1'b0;
    #100;
    for (int i = 0; i < 4; i++) begin
      uart_rxd_i = ((8'h5A >> i) & 8'h01) != 8'h00;
      #100;
    end
    uart_rxd_i = 1'b1;
    #50;
    sys_rst = 1'b1;
    #30;
    uart_rxd_i = 1'b1;
    #30;
    sys_rst = 1'b0;
    cycles(20);
    check("mr_done_n", 32'(done_cnt - d0), 32'd0);
    check("mr_err_n",  32'(err_cnt - e0), 32'd0);
    check("mr_data",   32'(uart_rxdata_o), 32'h00);
    check("mr_busy",   32'(uart_rx_busy_o), 32'd0);
    align();
    send_frame(8'h81, 1'b1, 100);
    cycles(20);
    check("mr81_done_n", 32'(done_cnt - d0), 32'd1);
    check("mr81_data",   32'(uart_rxdata_o), 32'h81);

    // +4% slow transmitter (10.4 clocks/bit)
    mark();
    align();
    send_frame(8'hC3, 1'b1, 104);
    cycles(20);
    check("slow_done_n", 32'(done_cnt - d0), 32'd1);
    check("slow_data",   qdata(0), 32'hC3);
    check("slow_err_n",  32'(err_cnt - e0), 32'd0);

    // -4% fast transmitter (9.6 clocks/bit)
    mark();
    align();
    send_frame(8'hC3, 1'b1, 96);
    cycles(20);
    check("fast_done_n", 32'(done_cnt - d0), 32'd1);
    check("fast_data",   qdata(0), 32'hC3);
    check("fast_err_n",  32'(err_cnt - e0), 32'd0);

    // pulse hygiene over the whole run
    check("done_err_overlap", 32'(both_cnt), 32'd0);
    check("pulse_width_gt1",  32'(long_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
